hilo_md_ctrl: RTL and testbench

HILO_MD_CTRL -- requirements
Module: hilo_md_ctrl

---
 rtl/hilo_md_ctrl.sv | 122 ++++++++++++
 tb/tb_hilo_md_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// HI/LO register file and handshake controller between the pipeline and a multi-cycle mult/div unit.
// Optional macro MD_DIVZERO_SKIP_EN: divide-by-zero requests bypass the unit and leave HI/LO untouched.
module hilo_md_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic        op_mult,
   input  logic        op_signed,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_mult,
   output logic        md_signed,
   output logic        md_enable,
   input  logic [31:0] md_res_h,
   input  logic [31:0] md_res_l,
   input  logic        md_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t      state_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic        mult_reg;
   logic        signed_reg;
   logic        enable_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic        accept;
   logic        skip;

`ifdef MD_DIVZERO_SKIP_EN
   assign skip = ~op_mult & (src_b == 32'd0);
`else
   assign skip = 1'b0;
`endif

   assign accept = (state_reg == IDLE) & op_valid & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= IDLE;
         a_reg      <= 32'd0;
         b_reg      <= 32'd0;
         mult_reg   <= 1'b0;
         signed_reg <= 1'b0;
         enable_reg <= 1'b0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               // MT writes land now; an op accepted this cycle overwrites them later
               if (mthi_we) hi_reg <= wdata;
               if (mtlo_we) lo_reg <= wdata;
               if (accept) begin
                  if (skip) begin
                     state_reg <= GAP;
                  end else begin
                     a_reg      <= src_a;
                     b_reg      <= src_b;
                     mult_reg   <= op_mult;
                     signed_reg <= op_signed;
                     enable_reg <= 1'b1;
                     state_reg  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  enable_reg <= 1'b0;
                  state_reg  <= GAP;
               end else if (md_ready) begin
                  hi_reg     <= md_res_h;
                  lo_reg     <= md_res_l;
                  enable_reg <= 1'b0;
                  state_reg  <= GAP;
               end
            end
            GAP: begin
               if (mthi_we) hi_reg <= wdata;
               if (mtlo_we) lo_reg <= wdata;
               state_reg <= IDLE;
            end
            default: begin
               enable_reg <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      if (rst) begin
         case (state_reg)
            IDLE:    stall = op_valid & ~flush;
            BUSY:    stall = ~md_ready & ~flush;
            GAP:     stall = op_valid;
            default: stall = 1'b0;
         endcase
      end
   end

   assign hi        = hi_reg;
   assign lo        = lo_reg;
   assign md_a      = a_reg;
   assign md_b      = b_reg;
   assign md_mult   = mult_reg;
   assign md_signed = signed_reg;
   assign md_enable = enable_reg;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: stimulus queues expected operands/results, a negedge monitor
// checks operands when md_enable rises and HI/LO when it falls.
module tb_hilo_md_ctrl;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic        op_mult;
   logic        op_signed;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_mult;
   logic        md_signed;
   logic        md_enable;
   logic [31:0] md_res_h;
   logic [31:0] md_res_l;
   logic        md_ready;

   hilo_md_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_mult   (op_mult),
      .op_signed (op_signed),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .mthi_we   (mthi_we),
      .mtlo_we   (mtlo_we),
      .wdata     (wdata),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo),
      .md_a      (md_a),
      .md_b      (md_b),
      .md_mult   (md_mult),
      .md_signed (md_signed),
      .md_enable (md_enable),
      .md_res_h  (md_res_h),
      .md_res_l  (md_res_l),
      .md_ready  (md_ready)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        mult;
      logic        sgn;
      logic [31:0] hi;
      logic [31:0] lo;
   } sb_t;

   sb_t         sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic        en_prev  = 1'b0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: operands on md_enable rise, HI/LO on md_enable fall
   always @(negedge clk) begin
      sb_t e;
      if (md_enable === 1'b1 && en_prev === 1'b0) begin
         check("sb_has_entry_on_issue", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb[0];
            check({e.name, "_md_a"}, md_a, e.a);
            check({e.name, "_md_b"}, md_b, e.b);
            check({e.name, "_md_mult"}, {31'd0, md_mult}, {31'd0, e.mult});
            check({e.name, "_md_signed"}, {31'd0, md_signed}, {31'd0, e.sgn});
         end
      end
      if (md_enable === 1'b0 && en_prev === 1'b1) begin
         check("sb_has_entry_on_done", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            $display("txn %s: hi=%h lo=%h (expected %h %h)", e.name, hi, lo, e.hi, e.lo);
         end
      end
      en_prev = md_enable;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic mult, input logic sgn, input int busy_wait,
                        input logic [31:0] rh, input logic [31:0] rl, input int flush_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit mt_accept, input int mthi_at, input bit gap_valid);
      sb_t e;
      int  stalls;
      int  exp_stalls;
      e.name = nm; e.a = a; e.b = b; e.mult = mult; e.sgn = sgn; e.hi = exp_hi; e.lo = exp_lo;
      sb.push_back(e);
      stalls     = 0;
      exp_stalls = ((flush_at >= 0) ? flush_at : busy_wait) + 1;
      op_valid = 1'b1; op_mult = mult; op_signed = sgn; src_a = a; src_b = b;
      if (mt_accept) begin mtlo_we = 1'b1; wdata = 32'hCAFEF00D; end
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk); #1;
      op_valid = 1'b0; mtlo_we = 1'b0; src_a = ~a; src_b = ~b; op_mult = ~mult;
      for (int i = 0; i <= busy_wait; i++) begin
         if (i == flush_at) flush = 1'b1;
         if (i == busy_wait) begin md_ready = 1'b1; md_res_h = rh; md_res_l = rl; end
         if (i == mthi_at) begin mthi_we = 1'b1; wdata = 32'h12345678; end
         @(negedge clk);
         if (stall) stalls++;
         check({nm, "_busy_en"}, {31'd0, md_enable}, 32'd1);
         check({nm, "_busy_a"}, md_a, a);
         if (i == 0 && mt_accept) check({nm, "_mtlo_on_accept"}, lo, 32'hCAFEF00D);
         if (mthi_at >= 0 && i == mthi_at + 1) check({nm, "_mthi_in_busy"}, hi, model_hi);
         @(posedge clk); #1;
         flush = 1'b0; md_ready = 1'b0; mthi_we = 1'b0;
         md_res_h = 32'hBAD0BAD0; md_res_l = 32'hBAD1BAD1;
         if (i == flush_at) break;
      end
      if (gap_valid) begin op_valid = 1'b1; op_mult = 1'b0; src_a = 32'd5; src_b = 32'd1; end
      @(negedge clk);
      check({nm, "_gap_en"}, {31'd0, md_enable}, 32'd0);
      check({nm, "_gap_stall"}, {31'd0, stall}, {31'd0, gap_valid});
      check({nm, "_stall_cycles"}, stalls, exp_stalls);
      @(posedge clk); #1;
      op_valid = 1'b0;
      model_hi = exp_hi;
      model_lo = exp_lo;
   endtask

   initial begin
      sb_t e;
      rst = 1'b0; op_valid = 1'b1; op_mult = 1'b0; op_signed = 1'b0;
      src_a = 32'd1; src_b = 32'd1; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
      wdata = 32'd0; md_res_h = 32'd0; md_res_l = 32'd0; md_ready = 1'b0;

      // reset with op_valid high: nothing accepted, stall held low
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_en", {31'd0, md_enable}, 32'd0);
      check("rst_md_a", md_a, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; op_valid = 1'b0;

      // MTHI in IDLE
      mthi_we = 1'b1; wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mthi_we = 1'b0;
      @(negedge clk);
      check("mthi_idle_hi", hi, 32'hDEADBEEF);
      check("mthi_idle_lo", lo, 32'd0);
      model_hi = 32'hDEADBEEF;

      // signed mult -2*3, one non-ready BUSY cycle; op_valid held during GAP
      do_op("smult", 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, -1,
            32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, -1, 1'b1);

      // unsigned div 100/7, 33 non-ready BUSY cycles
      do_op("udiv", 32'd100, 32'd7, 1'b0, 1'b0, 33, 32'd2, 32'd14, -1,
            32'd2, 32'd14, 1'b0, -1, 1'b0);

      // preload HI/LO for flush cases
      mthi_we = 1'b1; wdata = 32'h11;
      @(posedge clk); #1;
      mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h22;
      @(posedge clk); #1;
      mtlo_we = 1'b0;
      @(negedge clk);
      check("preload_hi", hi, 32'h11);
      check("preload_lo", lo, 32'h22);
      model_hi = 32'h11; model_lo = 32'h22;

      // flush at BUSY cycle 5 of a divide
      do_op("div_flush", 32'd1000, 32'd3, 1'b0, 1'b1, 40, 32'd0, 32'd0, 4,
            32'h11, 32'h22, 1'b0, -1, 1'b0);

      // flush and md_ready in the same cycle: flush wins
      do_op("flush_vs_ready", 32'd7, 32'd9, 1'b1, 1'b0, 2, 32'hAAAAAAAA, 32'h55555555, 2,
            32'h11, 32'h22, 1'b0, -1, 1'b0);

      // accept with MTLO same cycle, MTHI ignored in BUSY, result overwrites both
      do_op("umult_mt", 32'h00010000, 32'h00010000, 1'b1, 1'b0, 3, 32'd1, 32'd0, -1,
            32'd1, 32'd0, 1'b1, 1, 1'b0);

      // reset at BUSY cycle 3 discards the in-flight op
      e.name = "rst_mid"; e.a = 32'h40; e.b = 32'h3; e.mult = 1'b0; e.sgn = 1'b0;
      e.hi = 32'd0; e.lo = 32'd0;
      sb.push_back(e);
      op_valid = 1'b1; op_mult = 1'b0; op_signed = 1'b0; src_a = 32'h40; src_b = 32'h3;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0; op_valid = 1'b1;
      @(negedge clk);
      check("rst_mid_stall_low", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; op_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_en", {31'd0, md_enable}, 32'd0);
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      check("rst_mid_md_b", md_b, 32'd0);
      model_hi = 32'd0; model_lo = 32'd0;
      @(posedge clk); #1;

`ifdef MD_DIVZERO_SKIP_EN
      // divide-by-zero skips the unit
      op_valid = 1'b1; op_mult = 1'b0; op_signed = 1'b0; src_a = 32'd9; src_b = 32'd0;
      @(negedge clk);
      check("divz_stall_accept", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      check("divz_stall_after", {31'd0, stall}, 32'd0);
      check("divz_en", {31'd0, md_enable}, 32'd0);
      check("divz_hi", hi, model_hi);
      check("divz_lo", lo, model_lo);
      @(posedge clk); #1;
      @(negedge clk);
      check("divz_en_idle", {31'd0, md_enable}, 32'd0);
`else
      // divide-by-zero goes to the unit like any divide
      do_op("div_zero", 32'd9, 32'd0, 1'b0, 1'b0, 2, 32'd5, 32'hFFFFFFFF, -1,
            32'd5, 32'hFFFFFFFF, 1'b0, -1, 1'b0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
